temp_status_controller: RTL
===========================

Name: temp_status_controller

Overview:
Thermostat decision stage. It converts sampled greenhouse temperature readings and a setpoint into the 2-bit heating/cooling/idle status code consumed by the on-screen temperature status panel and by the actuator drivers. It applies hysteresis, a minimum dwell time between state changes, and a sensor-staleness watchdog. It sits between the sensor-interface block and the VGA status display.

Parameters:
TEMP_W, 8, width of temperature and setpoint values (unsigned, whole degrees C)
HYST, 2, hysteresis band in degrees; the heat/cool thresholds are setpoint -/+ HYST
TICK_DIV, 50_000_000, clk cycles per timing tick (1 s at 50 MHz)
MIN_DWELL, 10, minimum ticks a state is held after any non-forced transition
TIMEOUT, 5, ticks without temp_valid before sensor_fault is raised

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  0 forces IDLE, and holds it, on the next clk
temp  in  TEMP_W  current temperature sample
temp_valid  in  1  single-cycle strobe qualifying temp
setpoint  in  TEMP_W  target temperature, sampled every clk
status  out  2  00 idle, 01 heating, 10 cooling; 11 is never driven
heater_on  out  1  high exactly when status==01
cooler_on  out  1  high exactly when status==10
sensor_fault  out  1  watchdog expired; stays high until the next temp_valid
status_change  out  1  one-clk pulse in the cycle status takes a new value

Behaviour:
- Reset (async assert): status=00, heater_on=0, cooler_on=0, sensor_fault=0, status_change=0. Also cleared: temp register, have_sample flag, dwell counter, watchdog counter, prescaler.
- Tick: the prescaler counts 0..TICK_DIV-1 and pulses tick for 1 clk on wrap.
- Sample register: on temp_valid, load temp into t_reg, set have_sample, clear the watchdog.
- Threshold arithmetic: computed at TEMP_W+2 bits signed so that setpoint-HYST never wraps. Example: setpoint=1, HYST=2 gives low threshold -1.
- FSM states: IDLE, HEATING, COOLING. A transition is permitted only when dwell==0, have_sample==1 and enable==1. Transitions:
  - IDLE -> HEATING if t_reg < setpoint-HYST.
  - IDLE -> COOLING if t_reg > setpoint+HYST.
  - HEATING -> IDLE if t_reg >= setpoint.
  - COOLING -> IDLE if t_reg <= setpoint.
  - HEATING <-> COOLING directly is illegal; it always passes through IDLE and serves a full dwell there.
- Dwell: loaded with MIN_DWELL on every status change, decremented on tick, saturates at 0.
- Latency: status, heater_on and cooler_on are registered. Earliest change is 2 clks after the temp_valid cycle (1 clk to load t_reg, 1 clk for the FSM).
- Forced IDLE: enable==0 or watchdog expiry moves the FSM to IDLE on the next clk regardless of dwell, and reloads dwell. status_change pulses only if status actually changed.
- Watchdog: increments on tick and saturates at TIMEOUT. On reaching TIMEOUT it sets sensor_fault. Also clears have_sample, so the FSM stays in IDLE until a fresh sample arrives.
- Simultaneous tick and temp_valid in the same clk: temp_valid wins; the watchdog is cleared to 0.
- sensor_fault clears in the clk after temp_valid.
- After reset there is no sample, so the FSM stays IDLE. The watchdog runs from reset, so no sample for TIMEOUT ticks raises the fault.
- Reset asserted mid-dwell or mid-fault returns everything to reset values immediately.

Decomposition:
- Shared package holds the status encodings STATUS_IDLE=2'b00, STATUS_HEATING=2'b01, STATUS_COOLING=2'b10, for reuse by the display and actuator blocks.
- One sub-module, tick_prescaler: parameter TICK_DIV, ports clk, reset, tick.
- FSM, dwell counter and watchdog stay in the top level.

Test Plan:
Bench parameters for all cases: TICK_DIV=4, MIN_DWELL=3, TIMEOUT=8, HYST=2, setpoint=25, enable=1.
1. Reset, then no stimulus -> status=00, heater_on=0, cooler_on=0, status_change=0. sensor_fault rises after 8 ticks (32 clks).
2. temp=20 with temp_valid at cycle N -> status=01, heater_on=1, status_change=1 at N+2; status_change=0 at N+3.
3. From case 2, temp=25 valid 1 tick after entry -> status stays 01 until dwell reaches 0 (3 ticks after entry), then 00 next clk.
4. In IDLE after dwell: temp=27 valid -> status stays 00. Then temp=28 valid -> status=10, cooler_on=1. Then temp=20 while COOLING -> 00 after dwell, then 01 only after a further 3 ticks; never a direct 10->01 transition.
5. In HEATING, stop temp_valid for 8 ticks -> sensor_fault=1 and status=00 on the next clk, with dwell ignored. Then temp=20 valid -> sensor_fault=0, and status=01 only after 3 further ticks.
6. enable=0 while COOLING -> status=00 next clk. Separately, setpoint=1 with temp=0 valid -> status stays 00 (threshold -1, no underflow).

Source files
------------

// File: rtl/temp_status_controller_pkg.sv
// Shared status encodings for the thermostat decision stage, the status
// panel and the actuator drivers.
package temp_status_controller_pkg;

    localparam logic [1:0] STATUS_IDLE    = 2'b00;
    localparam logic [1:0] STATUS_HEATING = 2'b01;
    localparam logic [1:0] STATUS_COOLING = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = STATUS_IDLE,
        ST_HEATING = STATUS_HEATING,
        ST_COOLING = STATUS_COOLING
    } tsc_state_e;

endpackage

// File: rtl/temp_status_controller_tick_prescaler.sv
// Free-running divider producing a one-clk timing tick every TICK_DIV clks.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_r;

    // Count 0..TICK_DIV-1 and emit a registered pulse on wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/temp_status_controller.sv
// Thermostat decision stage: hysteresis, minimum dwell between state changes
// and a sensor-staleness watchdog driving the heating/cooling/idle status.
module temp_status_controller
    import temp_status_controller_pkg::*;
#(
    parameter int unsigned TEMP_W    = 8,
    parameter int unsigned HYST      = 2,
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned MIN_DWELL = 10,
    parameter int unsigned TIMEOUT   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [TEMP_W-1:0] temp,
    input  logic              temp_valid,
    input  logic [TEMP_W-1:0] setpoint,
    output logic [1:0]        status,
    output logic              heater_on,
    output logic              cooler_on,
    output logic              sensor_fault,
    output logic              status_change
);

    localparam int unsigned SW      = TEMP_W + 2;
    localparam int unsigned DWELL_W = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;
    localparam int unsigned WDOG_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [DWELL_W-1:0]   DWELL_INIT = DWELL_W'(MIN_DWELL);
    localparam logic [WDOG_W-1:0]    WDOG_LAST  = WDOG_W'(TIMEOUT - 1);
    localparam logic [WDOG_W-1:0]    WDOG_MAX   = WDOG_W'(TIMEOUT);
    localparam logic signed [SW-1:0] HYST_S     = SW'(HYST);

    logic                 tick_s;
    logic [TEMP_W-1:0]    t_r;
    logic                 have_sample_r;
    logic [WDOG_W-1:0]    wdog_r;
    logic                 sensor_fault_r;
    logic [DWELL_W-1:0]   dwell_r;
    tsc_state_e           state_r;
    tsc_state_e           state_next_s;
    logic                 heater_on_r;
    logic                 cooler_on_r;
    logic                 status_change_r;
    logic                 wdog_expire_s;
    logic                 force_idle_s;
    logic signed [SW-1:0] t_ext_s;
    logic signed [SW-1:0] sp_ext_s;
    logic signed [SW-1:0] thr_lo_s;
    logic signed [SW-1:0] thr_hi_s;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

    // Two guard bits keep setpoint-HYST from wrapping below zero.
    assign t_ext_s  = $signed({2'b00, t_r});
    assign sp_ext_s = $signed({2'b00, setpoint});
    assign thr_lo_s = sp_ext_s - HYST_S;
    assign thr_hi_s = sp_ext_s + HYST_S;

    assign wdog_expire_s = !temp_valid && tick_s && (wdog_r == WDOG_LAST);
    assign force_idle_s  = !enable || sensor_fault_r || wdog_expire_s;

    // Sample register and staleness watchdog; a fresh sample beats a tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t_r            <= '0;
            have_sample_r  <= 1'b0;
            wdog_r         <= '0;
            sensor_fault_r <= 1'b0;
        end else if (temp_valid) begin
            t_r            <= temp;
            have_sample_r  <= 1'b1;
            wdog_r         <= '0;
            sensor_fault_r <= 1'b0;
        end else if (tick_s && (wdog_r != WDOG_MAX)) begin
            wdog_r <= wdog_r + WDOG_W'(1);
            if (wdog_expire_s) begin
                sensor_fault_r <= 1'b1;
                have_sample_r  <= 1'b0;
            end
        end
    end

    // Next-state decision; heating and cooling only ever return to idle.
    always_comb begin
        state_next_s = state_r;
        if (force_idle_s) begin
            state_next_s = ST_IDLE;
        end else if ((dwell_r == '0) && have_sample_r) begin
            case (state_r)
                ST_IDLE: begin
                    if (t_ext_s < thr_lo_s) begin
                        state_next_s = ST_HEATING;
                    end else if (t_ext_s > thr_hi_s) begin
                        state_next_s = ST_COOLING;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_HEATING: begin
                    if (t_ext_s >= sp_ext_s) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_HEATING;
                    end
                end
                ST_COOLING: begin
                    if (t_ext_s <= sp_ext_s) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_COOLING;
                    end
                end
                default: state_next_s = ST_IDLE;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // State, registered outputs and dwell counter (reloaded on change or force).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            heater_on_r     <= 1'b0;
            cooler_on_r     <= 1'b0;
            status_change_r <= 1'b0;
            dwell_r         <= '0;
        end else begin
            state_r         <= state_next_s;
            heater_on_r     <= (state_next_s == ST_HEATING);
            cooler_on_r     <= (state_next_s == ST_COOLING);
            status_change_r <= (state_next_s != state_r);
            if (force_idle_s || (state_next_s != state_r)) begin
                dwell_r <= DWELL_INIT;
            end else if (tick_s && (dwell_r != '0)) begin
                dwell_r <= dwell_r - DWELL_W'(1);
            end else begin
                dwell_r <= dwell_r;
            end
        end
    end

    assign status        = state_r;
    assign heater_on     = heater_on_r;
    assign cooler_on     = cooler_on_r;
    assign sensor_fault  = sensor_fault_r;
    assign status_change = status_change_r;

endmodule
